wr_bus_master: RTL and testbench

//  Initiator side of the frontpanel parameter write bus (wr_en/wr_addr/wr_chan/wr_data)

---
 rtl/wr_bus_master_pkg.sv | 25 ++
 rtl/wr_cmd_fifo.sv | 59 +++++
 rtl/wr_bus_master.sv | 159 +++++++++++++++
 tb/tb_wr_bus_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wr_bus_master_pkg.sv
// Shared definitions for the parameter write-bus initiator: broadcast code,
// FSM encodings and the default bus payload layout.
package wr_bus_master_pkg;

    localparam int unsigned N_CHAN_DEF     = 8;
    localparam int unsigned W_WR_ADDR_DEF  = 16;
    localparam int unsigned W_WR_CHAN_DEF  = 16;
    localparam int unsigned W_WR_DATA_DEF  = 48;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned W_FIFO_DEF     = 4;

    localparam logic [15:0] BCAST_CHAN = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [W_WR_ADDR_DEF-1:0] addr;
        logic [W_WR_CHAN_DEF-1:0] chan;
        logic [W_WR_DATA_DEF-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/wr_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head and occupancy count.
module wr_cmd_fifo #(
    parameter int unsigned W_ENTRY = 80,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned W_PTR   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [W_ENTRY-1:0] din,
    output logic [W_ENTRY-1:0] head,
    output logic               full,
    output logic               empty,
    output logic [W_PTR:0]     level
);

    localparam int unsigned W_LVL = W_PTR + 1;

    logic [W_ENTRY-1:0] mem [DEPTH];
    logic [W_PTR-1:0]   wr_ptr;
    logic [W_PTR-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == W_LVL'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + W_PTR'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + W_PTR'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + W_LVL'(1);
            end else if (do_pop && !do_push) begin
                level <= level - W_LVL'(1);
            end
        end
    end

endmodule

// File: rtl/wr_bus_master.sv
// Frontpanel parameter write-bus initiator: FIFO-buffered host commands issued as
// single-cycle writes. Define WR_BCAST_EN to expand BCAST_CHAN into one write per channel.
module wr_bus_master
    import wr_bus_master_pkg::*;
#(
    parameter int unsigned N_CHAN     = N_CHAN_DEF,
    parameter int unsigned W_WR_ADDR  = W_WR_ADDR_DEF,
    parameter int unsigned W_WR_CHAN  = W_WR_CHAN_DEF,
    parameter int unsigned W_WR_DATA  = W_WR_DATA_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned W_FIFO     = W_FIFO_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [W_WR_ADDR-1:0] cmd_addr,
    input  logic [W_WR_CHAN-1:0] cmd_chan,
    input  logic [W_WR_DATA-1:0] cmd_data,
    output logic                 wr_en,
    output logic [W_WR_ADDR-1:0] wr_addr,
    output logic [W_WR_CHAN-1:0] wr_chan,
    output logic [W_WR_DATA-1:0] wr_data,
    output logic                 busy,
    output logic [W_FIFO:0]      level
);

    localparam int unsigned W_ENTRY = W_WR_ADDR + W_WR_CHAN + W_WR_DATA;

    if (FIFO_DEPTH < 2 || (1 << W_FIFO) != FIFO_DEPTH || N_CHAN < 1) begin : g_bad_param
        $error("wr_bus_master: inconsistent FIFO_DEPTH/W_FIFO/N_CHAN");
    end

    logic                 push_c;
    logic                 pop_c;
    logic                 full;
    logic                 empty;
    logic [W_ENTRY-1:0]   head;
    logic [W_WR_ADDR-1:0] head_addr;
    logic [W_WR_CHAN-1:0] head_chan;
    logic [W_WR_DATA-1:0] head_data;

    logic                 en_n;
    logic [W_WR_ADDR-1:0] addr_n;
    logic [W_WR_CHAN-1:0] chan_n;
    logic [W_WR_DATA-1:0] data_n;

    assign cmd_ready = !full;
    assign push_c    = cmd_valid && !full;
    assign {head_addr, head_chan, head_data} = head;

    wr_cmd_fifo #(
        .W_ENTRY (W_ENTRY),
        .DEPTH   (FIFO_DEPTH),
        .W_PTR   (W_FIFO)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (push_c),
        .pop   (pop_c),
        .din   ({cmd_addr, cmd_chan, cmd_data}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef WR_BCAST_EN
    localparam int unsigned W_BCNT = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    wr_state_e         state;
    wr_state_e         state_n;
    logic [W_BCNT-1:0] bcnt;
    logic [W_BCNT-1:0] bcnt_n;

    assign busy = !empty || (state != ST_IDLE);

    // Issue decision; wr_addr/wr_data double as the broadcast latch.
    always_comb begin
        pop_c   = 1'b0;
        en_n    = 1'b0;
        addr_n  = wr_addr;
        chan_n  = wr_chan;
        data_n  = wr_data;
        state_n = state;
        bcnt_n  = bcnt;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop_c  = 1'b1;
                    en_n   = 1'b1;
                    addr_n = head_addr;
                    chan_n = head_chan;
                    data_n = head_data;
                    if (head_chan == W_WR_CHAN'(BCAST_CHAN)) begin
                        chan_n = '0;
                        if (N_CHAN > 1) begin
                            state_n = ST_BCAST;
                            bcnt_n  = W_BCNT'(1);
                        end
                    end
                end
            end
            ST_BCAST: begin
                en_n   = 1'b1;
                chan_n = W_WR_CHAN'(bcnt);
                bcnt_n = bcnt + W_BCNT'(1);
                if (bcnt == W_BCNT'(N_CHAN - 1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
        end
    end
`else
    assign busy = !empty;

    // Every entry, broadcast code included, is one write.
    always_comb begin
        pop_c  = 1'b0;
        en_n   = 1'b0;
        addr_n = wr_addr;
        chan_n = wr_chan;
        data_n = wr_data;
        if (!empty) begin
            pop_c  = 1'b1;
            en_n   = 1'b1;
            addr_n = head_addr;
            chan_n = head_chan;
            data_n = head_data;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_chan <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= en_n;
            wr_addr <= addr_n;
            wr_chan <= chan_n;
            wr_data <= data_n;
        end
    end

endmodule

// File: tb/tb_wr_bus_master.sv
// Bench for wr_bus_master: directed and random command traffic against a
// queue-based model of the expected write stream (honours WR_BCAST_EN).
module tb_wr_bus_master;
    import wr_bus_master_pkg::*;

    localparam int DEPTH = 16;
    localparam int NCH   = 8;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_chan;
    logic [47:0] cmd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_chan;
    logic [47:0] wr_data;
    logic        busy;
    logic [4:0]  level;

    always #5 clk = ~clk;

    wr_bus_master dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_chan  (cmd_chan),
        .cmd_data  (cmd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_chan   (wr_chan),
        .wr_data   (wr_data),
        .busy      (busy),
        .level     (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: commands waiting in the FIFO, and writes still owed by the popped one.
    wr_cmd_t     mq[$];
    wr_cmd_t     pend[$];
    logic        e_en = 1'b0;
    logic [15:0] e_addr = '0;
    logic [15:0] e_chan = '0;
    logic [47:0] e_data = '0;
    bit          acc = 1'b0;
    bit          chk_en = 1'b0;
    bit          saw_full = 1'b0;
    int          n_wr = 0;

    task automatic model_step();
        wr_cmd_t c;
        wr_cmd_t w;
        acc = 1'b0;
        if (rst_in) begin
            mq.delete();
            pend.delete();
            e_en = 1'b0; e_addr = '0; e_chan = '0; e_data = '0;
        end else begin
            acc = cmd_valid && (mq.size() < DEPTH);
            if (pend.size() == 0 && mq.size() > 0) begin
                c = mq.pop_front();
`ifdef WR_BCAST_EN
                if (c.chan == BCAST_CHAN) begin
                    for (int i = 0; i < NCH; i++) begin
                        w = c;
                        w.chan = 16'(i);
                        pend.push_back(w);
                    end
                end else begin
                    pend.push_back(c);
                end
`else
                pend.push_back(c);
`endif
            end
            if (pend.size() > 0) begin
                w = pend.pop_front();
                e_en = 1'b1; e_addr = w.addr; e_chan = w.chan; e_data = w.data;
                n_wr++;
            end else begin
                e_en = 1'b0;
            end
            if (acc) begin
                c.addr = cmd_addr; c.chan = cmd_chan; c.data = cmd_data;
                mq.push_back(c);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("wr_en",     64'(wr_en),     64'(e_en));
            check("wr_addr",   64'(wr_addr),   64'(e_addr));
            check("wr_chan",   64'(wr_chan),   64'(e_chan));
            check("wr_data",   64'(wr_data),   64'(e_data));
            check("level",     64'(level),     64'(mq.size()));
            check("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
            check("busy",      64'(busy),      64'((mq.size() + pend.size()) != 0));
            if (level == 5'd16) saw_full = 1'b1;
        end
    end

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Hold a command until the model accepts it; returns on the following negedge.
    task automatic send(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_chan = c; cmd_data = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int base;
        int tgt;
        int n;
        rst_in = 1'b1; cmd_valid = 1'b1;
        cmd_addr = 16'h1234; cmd_chan = 16'h0001; cmd_data = 48'hDEAD;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0; cmd_valid = 1'b0;
        idle(2);

        // Unicast with explicit latency check
        send(16'h0010, 16'd3, 48'h123);
        @(posedge clk);
        #1;
        check("uni_lat_en",   64'(wr_en),   64'(1));
        check("uni_lat_chan", 64'(wr_chan), 64'(3));
        @(negedge clk);
        idle(3);

        for (int i = 0; i < 5; i++) send(16'h0020 + 16'(i), 16'(i), 48'({$urandom, $urandom}));
        idle(8);

        // Three broadcasts stall the output so the unicasts fill the FIFO
        for (int i = 0; i < 3; i++) send(16'h0030 + 16'(i), BCAST_CHAN, 48'h100 + 48'(i));
        for (int i = 0; i < DEPTH + 2; i++) send(16'h0040 + 16'(i), 16'(i % NCH), 48'({$urandom, $urandom}));
        idle(60);
`ifdef WR_BCAST_EN
        check("saw_full", 64'(saw_full), 64'(1));
`endif

        send(16'h0060, BCAST_CHAN, 48'hABC);
        send(16'h0061, 16'd2, 48'h555);
        idle(15);

        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_addr  = 16'($urandom);
            cmd_chan  = ($urandom_range(0, 7) == 0) ? BCAST_CHAN : 16'($urandom_range(0, 11));
            cmd_data  = 48'({$urandom, $urandom});
            @(negedge clk);
        end
        idle(160);

        // Reset part-way through a broadcast
        base = n_wr;
`ifdef WR_BCAST_EN
        tgt = base + 3;
`else
        tgt = base + 1;
`endif
        send(16'h0070, BCAST_CHAN, 48'hDEF);
        n = 0;
        while (n_wr < tgt && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_bcast_reach", 64'(n_wr >= tgt), 64'(1));
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("rst_mid_en",    64'(wr_en), 64'(0));
        check("rst_mid_level", 64'(level), 64'(0));
        idle(12);
        check("rst_mid_nowr",  64'(n_wr),  64'(tgt));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
